// File: rtl/cpu_pkg.sv
// Shared definitions for the core front end: default widths, reset PC,
// canonical NOP encoding and the fetch sequencer states.
package cpu_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instruction} pairs; head is presented combinationally
// (zero when empty). Flush discards every entry, including a same-cycle push.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        if (flush_i) begin
            rd_ptr_d = wr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited in-order requests to imem, prefetch
// FIFO toward decode, and redirect handling that drops stale in-flight responses.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic [FCW-1:0]  fifo_count;
    logic            fifo_full, fifo_empty;
    logic            fifo_push, fifo_pop;
    logic [CW:0]     credit_used;
    logic            req_fire;
    logic [XLEN-1:0] redirect_base;
    logic            unused_align;

    assign unused_align  = ^redirect_pc[1:0];
    assign redirect_base = {redirect_pc[XLEN-1:2], 2'b00};

    // Every outstanding request owns a FIFO slot, so the FIFO cannot overflow.
    assign credit_used    = {1'b0, outstanding_q} + (CW+1)'(fifo_count);
    assign imem_req_valid = (state_q != BOOT) && !fifo_full &&
                            (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign fifo_push  = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);
    assign inst_valid = !fifo_empty;
    assign fifo_pop   = inst_valid && inst_ready;

    always_comb begin
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_cnt_d    = drop_cnt_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        if (redirect_valid) begin
            // Everything still in flight after this cycle, including a request
            // accepted right now, belongs to the abandoned path.
            drop_cnt_d = outstanding_d;
            fetch_pc_d = redirect_base;
            rsp_pc_d   = redirect_base;
        end else begin
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (fifo_push) begin
                rsp_pc_d = rsp_pc_q + XLEN'(4);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:       state_d = RUN;
            RUN, DRAIN: state_d = (drop_cnt_d != '0) ? DRAIN : RUN;
            default:    state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i ({rsp_pc_q, imem_rsp_data}),
        .pop_i   (fifo_pop),
        .flush_i (redirect_valid),
        .rdata_o ({inst_pc, inst_data}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule
